// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-to-1 AXI3 read arbiter, tags AR with master index, routes R by ID.
// Define AXI_ARB_RR_EN for round-robin arbitration; default build is fixed priority.
module axi_rd_arbiter #(
  parameter int NUM_MST = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_MST*4-1:0]      s_arid,
  input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MST*4-1:0]      s_arlen,
  input  logic [NUM_MST*3-1:0]      s_arsize,
  input  logic [NUM_MST*2-1:0]      s_arburst,
  input  logic [NUM_MST-1:0]        s_arvalid,
  output logic [NUM_MST-1:0]        s_arready,
  output logic [NUM_MST*4-1:0]      s_rid,
  output logic [NUM_MST*DATA_W-1:0] s_rdata,
  output logic [NUM_MST*2-1:0]      s_rresp,
  output logic [NUM_MST-1:0]        s_rlast,
  output logic [NUM_MST-1:0]        s_rvalid,
  input  logic [NUM_MST-1:0]        s_rready,
  output logic [3:0]                m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [3:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [3:0]                m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);
  localparam int PW = $clog2(NUM_MST);

  logic [NUM_MST-1:0] busy;
  logic [NUM_MST-1:0] elig;
  logic [NUM_MST-1:0] set_vec;
  logic [NUM_MST-1:0] clr_vec;
  logic [3:0]         saved_id [NUM_MST];
  logic               gnt_cyc;
  logic               win_vld;
  logic [PW-1:0]      win;
  logic [3:0]         win_id;
  logic [ADDR_W-1:0]  win_addr;
  logic [3:0]         win_len;
  logic [2:0]         win_size;
  logic [1:0]         win_burst;
  logic [15:0]        busy_x;
  logic [15:0]        rdy_x;
  logic               hit;
  logic               beat_done;

  assign elig    = s_arvalid & ~busy;
  assign gnt_cyc = aresetn & (~m_arvalid | m_arready);

`ifdef AXI_ARB_RR_EN
  logic [PW-1:0]        rr_ptr;
  logic [2*NUM_MST-1:0] rot;
  logic [PW:0]          sum;

  // Rotate so the search starts at rr_ptr, then map the offset back.
  always_comb begin
    rot     = {elig, elig} >> rr_ptr;
    win_vld = 1'b0;
    sum     = '0;
    for (int j = NUM_MST-1; j >= 0; j--)
      if (rot[j]) begin
        win_vld = 1'b1;
        sum     = {1'b0, rr_ptr} + (PW+1)'(j);
      end
    if (sum >= (PW+1)'(NUM_MST))
      sum = sum - (PW+1)'(NUM_MST);
    win = sum[PW-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn)
      rr_ptr <= '0;
    else if (gnt_cyc && win_vld)
      rr_ptr <= (win == PW'(NUM_MST-1)) ? '0 : win + PW'(1);
`else
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int j = NUM_MST-1; j >= 0; j--)
      if (elig[j]) begin
        win_vld = 1'b1;
        win     = PW'(j);
      end
  end
`endif

  always_comb begin
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    win_size  = '0;
    win_burst = '0;
    for (int i = 0; i < NUM_MST; i++)
      if (win == PW'(i)) begin
        win_id    = s_arid[i*4 +: 4];
        win_addr  = s_araddr[i*ADDR_W +: ADDR_W];
        win_len   = s_arlen[i*4 +: 4];
        win_size  = s_arsize[i*3 +: 3];
        win_burst = s_arburst[i*2 +: 2];
      end
  end

  assign set_vec   = (gnt_cyc && win_vld) ? NUM_MST'(1) << win : '0;
  assign s_arready = set_vec;

  // Padded copies let any 4-bit rid index safely; out-of-range reads as idle.
  assign busy_x    = 16'(busy);
  assign rdy_x     = 16'(s_rready);
  assign hit       = busy_x[m_rid];
  assign m_rready  = ~hit | rdy_x[m_rid];
  assign beat_done = hit & m_rvalid & m_rready & m_rlast;

  always_comb begin
    s_rvalid = '0;
    clr_vec  = '0;
    for (int i = 0; i < NUM_MST; i++)
      if (m_rid == 4'(i)) begin
        s_rvalid[i] = hit & m_rvalid;
        clr_vec[i]  = beat_done;
      end
  end

  for (genvar g = 0; g < NUM_MST; g++) begin : g_slot
    assign s_rid[g*4 +: 4]           = saved_id[g];
    assign s_rdata[g*DATA_W +: DATA_W] = m_rdata;
    assign s_rresp[g*2 +: 2]         = m_rresp;
    assign s_rlast[g]                = m_rlast;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      busy      <= '0;
      for (int i = 0; i < NUM_MST; i++)
        saved_id[i] <= '0;
    end else begin
      if (gnt_cyc) begin
        m_arvalid <= win_vld;
        if (win_vld) begin
          m_arid    <= 4'(win);
          m_araddr  <= win_addr;
          m_arlen   <= win_len;
          m_arsize  <= win_size;
          m_arburst <= win_burst;
        end
      end
      for (int i = 0; i < NUM_MST; i++)
        if (set_vec[i])
          saved_id[i] <= win_id;
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed sequences, an R-routing vector table and
// random traffic checked against a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*4-1:0]  s_arid;
  logic [N*AW-1:0] s_araddr;
  logic [N*4-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [N*4-1:0]  s_rid;
  logic [N*DW-1:0] s_rdata;
  logic [N*2-1:0]  s_rresp;
  logic [N-1:0]    s_rlast;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;
  logic [3:0]      m_arid;
  logic [AW-1:0]   m_araddr;
  logic [3:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [3:0]      m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;

  axi_rd_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(clk), .aresetn(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: who holds a burst, its original ID, the AR slot.
  bit            mb [N];
  logic [3:0]    msid [N];
  int            mptr;
  bit            mv;
  logic [3:0]    mid;
  logic [AW-1:0] maddr;
  logic [3:0]    mlen;
  logic [2:0]    msz;
  logic [1:0]    mbur;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mb[i]   = 0;
      msid[i] = '0;
    end
    mptr = 0; mv = 0; mid = '0; maddr = '0;
    mlen = '0; msz = '0; mbur = '0;
  endtask

  function automatic int pick();
    for (int j = 0; j < N; j++) begin
`ifdef AXI_ARB_RR_EN
      int i = (mptr + j) % N;
`else
      int i = j;
`endif
      if (s_arvalid[i] && !mb[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outs();
    int w;
    int k;
    bit hit;
    bit e_rr;
    logic [N-1:0] e_ar;
    logic [N-1:0] e_rv;
    if (!rst_n) model_reset();
    w    = (rst_n && (!mv || m_arready)) ? pick() : -1;
    e_ar = (w >= 0) ? (N'(1) << w) : '0;
    chk("s_arready", s_arready, e_ar);
    chk("m_arvalid", m_arvalid, mv);
    if (mv)
      chk("m_ar_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
          {mid, maddr, mlen, msz, mbur});
    k    = int'(m_rid);
    hit  = (k < N) && mb[k];
    e_rr = hit ? s_rready[k] : 1'b1;
    e_rv = (hit && m_rvalid) ? (N'(1) << k) : '0;
    chk("m_rready", m_rready, e_rr);
    chk("s_rvalid", s_rvalid, e_rv);
    chk("s_rresp_rlast", {s_rresp, s_rlast}, {{N{m_rresp}}, {N{m_rlast}}});
    if (hit) begin
      chk("s_rid", s_rid[k*4 +: 4], msid[k]);
      chk("s_rdata", s_rdata[k*DW +: DW], m_rdata);
    end
  endtask

  task automatic update_model();
    int w;
    int k;
    bit g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = !mv || m_arready;
    w = g ? pick() : -1;
    k = int'(m_rid);
    if (m_rvalid && k < N && mb[k] && s_rready[k] && m_rlast) mb[k] = 0;
    if (g) begin
      mv = (w >= 0);
      if (w >= 0) begin
        mid     = 4'(w);
        maddr   = s_araddr[w*AW +: AW];
        mlen    = s_arlen[w*4 +: 4];
        msz     = s_arsize[w*3 +: 3];
        mbur    = s_arburst[w*2 +: 2];
        mb[w]   = 1;
        msid[w] = s_arid[w*4 +: 4];
        mptr    = (w + 1) % N;
      end
    end
  endtask

  task automatic samp();
    @(negedge clk);
    check_outs();
  endtask

  task automatic adv();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_rready = '1; m_arready = 1'b1;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    samp();
    adv();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]   rid;
    logic         v;
    logic [N-1:0] rr;
    logic         e_mrr;
    logic [N-1:0] e_srv;
    logic [3:0]   e_sid;
  } rvec_t;

  rvec_t tbl [9];

  initial begin
    // Masters 0 (id A) and 1 (id 5) busy, master 2 idle.
    tbl[0] = '{4'd1,  1'b1, 3'b111, 1'b1, 3'b010, 4'h5};
    tbl[1] = '{4'd0,  1'b1, 3'b110, 1'b0, 3'b001, 4'hA};
    tbl[2] = '{4'd0,  1'b1, 3'b110, 1'b0, 3'b001, 4'hA};
    tbl[3] = '{4'd0,  1'b1, 3'b111, 1'b1, 3'b001, 4'hA};
    tbl[4] = '{4'd2,  1'b1, 3'b000, 1'b1, 3'b000, 4'h0};
    tbl[5] = '{4'd5,  1'b1, 3'b000, 1'b1, 3'b000, 4'h0};
    tbl[6] = '{4'd15, 1'b1, 3'b000, 1'b1, 3'b000, 4'h0};
    tbl[7] = '{4'd1,  1'b0, 3'b101, 1'b0, 3'b000, 4'h0};
    tbl[8] = '{4'd0,  1'b0, 3'b111, 1'b1, 3'b000, 4'h0};

    model_reset();
    idle();
    rst_n = 1'b0;
    s_arvalid = 3'b011;
    samp();
    chk("rst m_arvalid", m_arvalid, 0);
    chk("rst payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, 0);
    chk("rst s_arready", s_arready, 0);
    adv();
    idle();
    rst_n = 1'b1;

    // Single 8-beat burst from master 1
    s_arvalid = 3'b010;
    s_arid    = 12'h030;
    s_araddr  = {32'h0, 32'h1FC0_0000, 32'h0};
    s_arlen   = 12'h070;
    s_arsize  = {3'd0, 3'd2, 3'd0};
    s_arburst = 6'b00_01_00;
    samp();
    chk("t1 s_arready", s_arready, 3'b010);
    adv();
    s_arvalid = '0;
    samp();
    chk("t1 m_arvalid", m_arvalid, 1);
    chk("t1 m_arid", m_arid, 1);
    chk("t1 m_araddr", m_araddr, 32'h1FC0_0000);
    chk("t1 m_arlen", m_arlen, 7);
    adv();
    for (int b = 0; b < 8; b++) begin
      m_rvalid = 1'b1;
      m_rid    = 4'd1;
      m_rlast  = (b == 7);
      m_rdata  = 32'hD000_0000 + b;
      samp();
      chk("t1 s_rvalid", s_rvalid, 3'b010);
      chk("t1 s_rid", s_rid[7:4], 4'h3);
      chk("t1 s_rdata", s_rdata[63:32], 32'hD000_0000 + b);
      adv();
    end
    samp();
    chk("t1 stray s_rvalid", s_rvalid, 3'b000);
    chk("t1 stray m_rready", m_rready, 1);
    adv();
    idle();

    // AR stall: m_arready low for 5 cycles
    do_reset();
    s_arvalid = 3'b101;
    s_arid    = 12'h201;
    s_araddr  = {32'h2000, 32'h0, 32'h1000};
    m_arready = 1'b0;
    samp();
    chk("t3 first grant", s_arready, 3'b001);
    adv();
    for (int c = 0; c < 5; c++) begin
      samp();
      chk("t3 stall s_arready", s_arready, 3'b000);
      chk("t3 stall m_arvalid", m_arvalid, 1);
      chk("t3 stall m_araddr", m_araddr, 32'h1000);
      chk("t3 stall m_arid", m_arid, 0);
      adv();
    end
    m_arready = 1'b1;
    samp();
    chk("t3 release grant", s_arready, 3'b100);
    adv();
    samp();
    chk("t3 m_arid", m_arid, 2);
    chk("t3 m_araddr", m_araddr, 32'h2000);
    adv();
    idle();

    // Back-to-back grants then R routing table
    do_reset();
    s_arvalid = 3'b011;
    s_arid    = 12'h05A;
    samp();
    chk("t2 grant0", s_arready, 3'b001);
    adv();
    samp();
    chk("t2 grant1", s_arready, 3'b010);
    adv();
    samp();
    chk("t2 all busy", s_arready, 3'b000);
    adv();
    s_arvalid = '0;
    for (int i = 0; i < 9; i++) begin
      m_rid    = tbl[i].rid;
      m_rvalid = tbl[i].v;
      s_rready = tbl[i].rr;
      m_rdata  = 32'hA5A5_0000 + i;
      samp();
      chk("tbl m_rready", m_rready, tbl[i].e_mrr);
      chk("tbl s_rvalid", s_rvalid, tbl[i].e_srv);
      if (tbl[i].e_srv != 0)
        chk("tbl s_rid", s_rid[tbl[i].rid*4 +: 4], tbl[i].e_sid);
      adv();
    end
    m_rid = 4'd0; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = '1;
    samp();
    chk("t5 last m_rready", m_rready, 1);
    chk("t5 last s_rvalid", s_rvalid, 3'b001);
    adv();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    s_arvalid = 3'b011;
    samp();
    chk("t5 regrant", s_arready, 3'b001);
    adv();
    idle();

    // Reset during beat 3 of 8
    do_reset();
    s_arvalid = 3'b010;
    s_arid    = 12'h030;
    s_arlen   = 12'h070;
    samp();
    adv();
    s_arvalid = '0;
    samp();
    adv();
    for (int b = 0; b < 3; b++) begin
      m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0;
      if (b == 2) rst_n = 1'b0;
      samp();
      if (b < 2) chk("t6 pre s_rvalid", s_rvalid, 3'b010);
      adv();
    end
    chk("t6 rst m_arvalid", m_arvalid, 0);
    chk("t6 rst s_rvalid", s_rvalid, 3'b000);
    rst_n = 1'b1;
    s_rready = '0;
    for (int b = 3; b < 8; b++) begin
      m_rlast = (b == 7);
      samp();
      chk("t6 sunk m_rready", m_rready, 1);
      chk("t6 sunk s_rvalid", s_rvalid, 3'b000);
      adv();
    end
    idle();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_arvalid = N'($urandom);
      s_arid    = 12'($urandom);
      s_araddr  = {$urandom, $urandom, $urandom};
      s_arlen   = 12'($urandom);
      s_arsize  = 9'($urandom);
      s_arburst = 6'($urandom);
      m_arready = ($urandom_range(0, 3) != 0);
      m_rvalid  = 1'($urandom_range(0, 1));
      m_rid     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15))
                                              : 4'($urandom_range(0, 2));
      m_rlast   = ($urandom_range(0, 3) == 0);
      m_rdata   = $urandom;
      m_rresp   = 2'($urandom);
      s_rready  = N'($urandom | $urandom);
      samp();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
